// File: rtl/bp_burst_mem_responder.sv
// bp_burst_mem_responder: one-at-a-time burst memory model with fixed latency.
// Ports: blackparrot_clk; blackparrot_reset (async, active-low);
//   mem_cmd_header_* / mem_cmd_data_*: inbound valid/ready-and command channels;
//   mem_resp_header_* / mem_resp_data_*: outbound valid/ready-and response channels.
module bp_burst_mem_responder #(
    parameter int dword_width_p = 64,
    parameter int paddr_width_p = 40,
    parameter int hdr_width_p = 128,
    parameter int mem_els_p = 512,
    parameter logic [paddr_width_p-1:0] mem_offset_p = 40'h80_0000_0000 >> 8,
    parameter int latency_p = 8
) (
    input  logic                     blackparrot_clk,
    input  logic                     blackparrot_reset,
    input  logic [hdr_width_p-1:0]   mem_cmd_header_i,
    input  logic                     mem_cmd_header_v_i,
    output logic                     mem_cmd_header_ready_and_o,
    input  logic [dword_width_p-1:0] mem_cmd_data_i,
    input  logic                     mem_cmd_data_v_i,
    output logic                     mem_cmd_data_ready_and_o,
    output logic [hdr_width_p-1:0]   mem_resp_header_o,
    output logic                     mem_resp_header_v_o,
    input  logic                     mem_resp_header_ready_and_i,
    output logic [dword_width_p-1:0] mem_resp_data_o,
    output logic                     mem_resp_data_v_o,
    input  logic                     mem_resp_data_ready_and_i
);

    localparam int BYTES_C = dword_width_p / 8;
    localparam int OFF_W = $clog2(BYTES_C);
    localparam int IDX_W = $clog2(mem_els_p);
    localparam int LAT_W = (latency_p > 0) ? $clog2(latency_p + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_C = LAT_W'(latency_p);
    localparam int SZ_LSB = 4 + paddr_width_p;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_DATA,
        S_WAIT,
        S_RESP_HDR,
        S_RESP_DATA
    } state_e;

    state_e r_state;
    state_e w_state_n;

    logic [hdr_width_p-1:0] r_hdr;
    logic [4:0] r_beat;
    logic [4:0] w_beat_n;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_cnt_n;
    logic w_hdr_ld;
    logic w_we;

    // Backing store; deliberately left without reset.
    logic [dword_width_p-1:0] r_mem [mem_els_p];

    logic [3:0] w_type;
    logic [3:0] w_in_type;
    logic [paddr_width_p-1:0] w_addr;
    logic [paddr_width_p-1:0] w_rel;
    logic [paddr_width_p-1:0] w_dw;
    logic [paddr_width_p-1:0] w_nm1;
    logic [paddr_width_p-1:0] w_lin;
    logic [2:0] w_size;
    logic [7:0] w_bytes;
    logic [7:0] w_nbeats;
    logic w_full;
    logic w_last;
    logic w_is_rd;
    logic w_in_wr;
    logic [OFF_W-1:0] w_boff;
    logic [IDX_W-1:0] w_idx;
    logic [BYTES_C-1:0] w_wmask;
    logic [dword_width_p-1:0] w_wdata;
    logic [dword_width_p-1:0] w_rd_raw;
    logic [dword_width_p-1:0] w_rd_sh;
    logic [dword_width_p-1:0] w_rdata;

    assign w_type = r_hdr[3:0];
    assign w_addr = r_hdr[4 +: paddr_width_p];
    assign w_size = r_hdr[SZ_LSB +: 3];
    assign w_in_type = mem_cmd_header_i[3:0];
    assign w_in_wr = (w_in_type == 4'd1) || (w_in_type == 4'd3);
    assign w_is_rd = (w_type == 4'd0) || (w_type == 4'd2);

    assign w_bytes = 8'd1 << w_size;
    assign w_full = (w_bytes >= 8'(BYTES_C));
    assign w_nbeats = w_full ? (w_bytes >> OFF_W) : 8'd1;
    assign w_last = ({3'b000, r_beat} == (w_nbeats - 8'd1));

    // Critical-word-first: start at the addressed dword, wrap inside the
    // naturally aligned N-dword block, then wrap into the store.
    assign w_rel = w_addr - mem_offset_p;
    assign w_dw = w_rel >> OFF_W;
    assign w_nm1 = paddr_width_p'(w_nbeats - 8'd1);
    assign w_lin = (w_dw & ~w_nm1)
                 + ((w_dw + paddr_width_p'(r_beat)) & w_nm1);
    assign w_idx = IDX_W'(w_lin % paddr_width_p'(mem_els_p));
    assign w_boff = w_addr[OFF_W-1:0];

    // Sub-dword lanes: writes land at the byte offset, reads come back
    // right-justified; anything past the top of the dword is dropped.
    always_comb begin
        w_wmask = '0;
        w_rdata = '0;
        w_rd_raw = r_mem[w_idx];
        w_wdata = w_full ? mem_cmd_data_i
                         : (mem_cmd_data_i << {w_boff, 3'b000});
        w_rd_sh = w_full ? w_rd_raw
                         : (w_rd_raw >> {w_boff, 3'b000});
        for (int b = 0; b < BYTES_C; b++) begin
            if (w_full || ((b >= int'(w_boff))
                && (b < int'(w_boff) + int'(w_bytes)))) begin
                w_wmask[b] = 1'b1;
            end
            if (w_full || (b < int'(w_bytes))) begin
                w_rdata[b*8 +: 8] = w_rd_sh[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge blackparrot_clk) begin
        if (w_we) begin
            for (int b = 0; b < BYTES_C; b++) begin
                if (w_wmask[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
        if (!blackparrot_reset) begin
            r_state <= S_IDLE;
            r_beat <= '0;
            r_cnt <= '0;
            r_hdr <= '0;
        end else begin
            r_state <= w_state_n;
            r_beat <= w_beat_n;
            r_cnt <= w_cnt_n;
            if (w_hdr_ld) begin
                r_hdr <= mem_cmd_header_i;
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_beat_n = r_beat;
        w_cnt_n = r_cnt;
        w_hdr_ld = 1'b0;
        w_we = 1'b0;
        mem_cmd_header_ready_and_o = 1'b0;
        mem_cmd_data_ready_and_o = 1'b0;
        mem_resp_header_o = '0;
        mem_resp_header_v_o = 1'b0;
        mem_resp_data_o = '0;
        mem_resp_data_v_o = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // Gated by reset so ready is low while reset is held.
                mem_cmd_header_ready_and_o = blackparrot_reset;
                if (mem_cmd_header_v_i && blackparrot_reset) begin
                    w_hdr_ld = 1'b1;
                    w_beat_n = '0;
                    if (w_in_wr) begin
                        w_state_n = S_CMD_DATA;
                    end else begin
                        w_state_n = (latency_p == 0) ? S_RESP_HDR : S_WAIT;
                        w_cnt_n = LAT_C;
                    end
                end
            end
            S_CMD_DATA: begin
                mem_cmd_data_ready_and_o = 1'b1;
                if (mem_cmd_data_v_i) begin
                    w_we = 1'b1;
                    if (w_last) begin
                        w_beat_n = '0;
                        w_state_n = (latency_p == 0) ? S_RESP_HDR : S_WAIT;
                        w_cnt_n = LAT_C;
                    end else begin
                        w_beat_n = r_beat + 5'd1;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_n = r_cnt - LAT_W'(1);
                if (r_cnt == LAT_W'(1)) begin
                    w_state_n = S_RESP_HDR;
                end
            end
            S_RESP_HDR: begin
                mem_resp_header_v_o = 1'b1;
                mem_resp_header_o = r_hdr;
                if (mem_resp_header_ready_and_i) begin
                    w_beat_n = '0;
                    w_state_n = w_is_rd ? S_RESP_DATA : S_IDLE;
                end
            end
            S_RESP_DATA: begin
                mem_resp_data_v_o = 1'b1;
                mem_resp_data_o = w_rdata;
                if (mem_resp_data_ready_and_i) begin
                    if (w_last) begin
                        w_beat_n = '0;
                        w_state_n = S_IDLE;
                    end else begin
                        w_beat_n = r_beat + 5'd1;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bp_burst_mem_responder.sv
// tb_bp_burst_mem_responder: directed + randomized bench with a
// byte-level reference memory for bp_burst_mem_responder.
module tb_bp_burst_mem_responder;

    localparam int LAT = 8;
    localparam logic [39:0] BASE = 40'h80_0000_0000 >> 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [127:0] ch [2];
    logic chv [2];
    logic chr [2];
    logic [63:0] cd [2];
    logic cdv [2];
    logic cdr [2];
    logic [127:0] rh [2];
    logic rhv [2];
    logic rhr [2];
    logic [63:0] rdo [2];
    logic rdv [2];
    logic rdr [2];

    bp_burst_mem_responder #(.latency_p(LAT)) dut (
        .blackparrot_clk(clk),
        .blackparrot_reset(rst_n),
        .mem_cmd_header_i(ch[0]),
        .mem_cmd_header_v_i(chv[0]),
        .mem_cmd_header_ready_and_o(chr[0]),
        .mem_cmd_data_i(cd[0]),
        .mem_cmd_data_v_i(cdv[0]),
        .mem_cmd_data_ready_and_o(cdr[0]),
        .mem_resp_header_o(rh[0]),
        .mem_resp_header_v_o(rhv[0]),
        .mem_resp_header_ready_and_i(rhr[0]),
        .mem_resp_data_o(rdo[0]),
        .mem_resp_data_v_o(rdv[0]),
        .mem_resp_data_ready_and_i(rdr[0])
    );

    bp_burst_mem_responder #(.latency_p(0)) dut_l0 (
        .blackparrot_clk(clk),
        .blackparrot_reset(rst_n),
        .mem_cmd_header_i(ch[1]),
        .mem_cmd_header_v_i(chv[1]),
        .mem_cmd_header_ready_and_o(chr[1]),
        .mem_cmd_data_i(cd[1]),
        .mem_cmd_data_v_i(cdv[1]),
        .mem_cmd_data_ready_and_o(cdr[1]),
        .mem_resp_header_o(rh[1]),
        .mem_resp_header_v_o(rhv[1]),
        .mem_resp_header_ready_and_i(rhr[1]),
        .mem_resp_data_o(rdo[1]),
        .mem_resp_data_v_o(rdv[1]),
        .mem_resp_data_ready_and_i(rdr[1])
    );

    int errors = 0;
    int checks = 0;
    logic [63:0] mm [2][512];
    logic [63:0] wb [8];
    logic [63:0] cap [8];

    task automatic chk(input string tag, input logic [127:0] o,
                       input logic [127:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic int nbeats(input int sz);
        return (sz <= 3) ? 1 : (1 << (sz - 3));
    endfunction

    function automatic int didx(input logic [39:0] a, input int sz,
                                input int i);
        logic [39:0] rel;
        longint unsigned dw;
        longint unsigned n;
        rel = a - BASE;
        dw = 64'(rel >> 3);
        n = 64'(nbeats(sz));
        return int'(((dw / n) * n + ((dw + 64'(i)) % n)) % 64'd512);
    endfunction

    task automatic model_write(input int d, input logic [39:0] a,
                               input int sz, input int i,
                               input logic [63:0] data);
        int x;
        int off;
        logic [63:0] w;
        x = didx(a, sz, i);
        off = int'(a[2:0]);
        w = mm[d][x];
        if (sz >= 3) begin
            w = data;
        end else begin
            for (int k = 0; k < (1 << sz); k++) begin
                if (off + k < 8) w[(off+k)*8 +: 8] = data[k*8 +: 8];
            end
        end
        mm[d][x] = w;
    endtask

    function automatic logic [63:0] model_read(input int d,
                                               input logic [39:0] a,
                                               input int sz, input int i);
        int off;
        logic [63:0] w;
        logic [63:0] r;
        w = mm[d][didx(a, sz, i)];
        off = int'(a[2:0]);
        r = '0;
        if (sz >= 3) begin
            r = w;
        end else begin
            for (int k = 0; k < (1 << sz); k++) begin
                if (off + k < 8) r[k*8 +: 8] = w[(off+k)*8 +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [80:0] rpl();
        return {17'($urandom), $urandom, $urandom};
    endfunction

    task automatic txn(input int d, input logic [3:0] t,
                       input logic [39:0] a, input logic [2:0] sz,
                       input logic [80:0] pl, input int hst,
                       input int dst);
        logic [127:0] h;
        logic [63:0] ex;
        int n;
        int w;
        int lat;
        bit ok;
        h = {pl, sz, a, t};
        n = nbeats(int'(sz));
        @(negedge clk);
        ch[d] = h;
        chv[d] = 1'b1;
        w = 0;
        while (!chr[d] && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("hdr_accept", 128'(chr[d]), 128'(1));
        @(posedge clk);
        #1 chv[d] = 1'b0;
        ch[d] = '0;
        if (t == 4'd1 || t == 4'd3) begin
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                cd[d] = wb[i];
                cdv[d] = 1'b1;
                w = 0;
                while (!cdr[d] && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                chk("data_accept", 128'(cdr[d]), 128'(1));
                @(posedge clk);
                #1 cdv[d] = 1'b0;
                model_write(d, a, int'(sz), i, wb[i]);
            end
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rhv[d] && lat < 60);
        chk("resp_latency", 128'(lat), 128'(((d == 0) ? LAT : 0) + 1));
        if (hst > 0) begin
            ok = 1'b1;
            for (int s = 0; s < hst; s++) begin
                ok &= (rh[d] === h) && (rhv[d] === 1'b1) && (rdv[d] === 1'b0);
                @(negedge clk);
            end
            chk("hdr_stall_stable", 128'(ok), 128'(1));
        end
        chk("resp_hdr", {rh[d][126:0], rhv[d]}, {h[126:0], 1'b1});
        chk("resp_hdr_msb", 128'(rh[d][127]), 128'(h[127]));
        rhr[d] = 1'b1;
        @(posedge clk);
        #1 rhr[d] = 1'b0;
        if (t == 4'd0 || t == 4'd2) begin
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                ex = model_read(d, a, int'(sz), i);
                if (dst > 0 && (i % 4) == 0) begin
                    ok = 1'b1;
                    for (int s = 0; s < dst; s++) begin
                        ok &= (rdv[d] === 1'b1) && (rdo[d] === ex);
                        @(negedge clk);
                    end
                    chk("data_stall_stable", 128'(ok), 128'(1));
                end
                chk("rd_beat", 128'({rdv[d], rdo[d]}), 128'({1'b1, ex}));
                if (i < 8) cap[i] = rdo[d];
                rdr[d] = 1'b1;
                @(posedge clk);
                #1 rdr[d] = 1'b0;
            end
        end
        @(negedge clk);
        chk("idle_ctl", 128'({chr[d], cdr[d], rhv[d], rdv[d]}),
            128'(4'b1000));
        chk("idle_zero", rh[d] | 128'(rdo[d]), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] t;
        logic [2:0] sz;
        logic [39:0] a;
        int wt;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ch[d] = '0;
            chv[d] = 1'b0;
            cd[d] = '0;
            cdv[d] = 1'b0;
            rhr[d] = 1'b0;
            rdr[d] = 1'b0;
        end
        #1;
        chk("reset_ctl", 128'({chr[0], cdr[0], rhv[0], rdv[0]}), 128'(0));
        chk("reset_vals", rh[0] | 128'(rdo[0]), 128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_reset", 128'(chr[0]), 128'(1));

        for (int blk = 0; blk < 8; blk++) begin
            for (int i = 0; i < 8; i++) wb[i] = {$urandom, $urandom};
            txn(0, 4'd1, BASE + 40'(blk * 64), 3'd6, rpl(), 0, 0);
        end

        for (int i = 0; i < 8; i++) wb[i] = 64'(17 * (i + 1));
        txn(0, 4'd1, 40'h80_0000_0040, 3'd6, rpl(), 0, 0);
        txn(0, 4'd0, 40'h80_0000_0050, 3'd6, rpl(), 0, 0);
        chk("cwf_first", 128'(cap[0]), 128'(64'h33));
        chk("cwf_wrap6", 128'(cap[6]), 128'(64'h11));
        chk("cwf_last", 128'(cap[7]), 128'(64'h22));

        wb[0] = 64'h0;
        txn(0, 4'd3, 40'h80_0000_0000, 3'd3, rpl(), 0, 0);
        wb[0] = 64'hAB;
        txn(0, 4'd3, 40'h80_0000_0003, 3'd0, rpl(), 0, 0);
        txn(0, 4'd2, 40'h80_0000_0000, 3'd3, rpl(), 0, 0);
        chk("uc_byte_merge", 128'(cap[0]), 128'(64'h0000_0000_AB00_0000));

        txn(0, 4'd0, 40'h80_0000_0080, 3'd6, rpl(), 5, 3);

        txn(0, 4'd7, 40'h80_0000_0008, 3'd3, 81'h5A, 0, 0);
        txn(0, 4'd2, 40'h80_0000_0008, 3'd3, rpl(), 0, 0);

        txn(0, 4'd2, 40'h80_0000_1000, 3'd3, rpl(), 0, 0);

        for (int i = 0; i < 8; i++) wb[i] = {$urandom, $urandom};
        @(negedge clk);
        ch[0] = {81'h0, 3'd6, 40'h80_0000_0100, 4'd1};
        chv[0] = 1'b1;
        wt = 0;
        while (!chr[0] && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        @(posedge clk);
        #1 chv[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cd[0] = wb[i];
            cdv[0] = 1'b1;
            chk("rst_wr_ready", 128'(cdr[0]), 128'(1));
            @(posedge clk);
            #1 cdv[0] = 1'b0;
            model_write(0, 40'h80_0000_0100, 6, i, wb[i]);
        end
        @(negedge clk);
        cd[0] = wb[3];
        cdv[0] = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ctl", 128'({chr[0], cdr[0], rhv[0], rdv[0]}), 128'(0));
        chk("midrst_vals", rh[0] | 128'(rdo[0]), 128'(0));
        cdv[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_midrst", 128'(chr[0]), 128'(1));
        txn(0, 4'd0, 40'h80_0000_0100, 3'd6, rpl(), 0, 0);

        for (int i = 0; i < 8; i++) wb[i] = {$urandom, $urandom};
        txn(1, 4'd1, 40'h80_0000_0040, 3'd6, rpl(), 0, 0);
        txn(1, 4'd0, 40'h80_0000_0058, 3'd6, rpl(), 0, 0);
        txn(1, 4'd2, 40'h80_0000_0044, 3'd2, rpl(), 2, 1);

        for (int r = 0; r < 14; r++) begin
            for (int i = 0; i < 8; i++) wb[i] = {$urandom, $urandom};
            t = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd3;
            sz = 3'($urandom_range(0, 6));
            a = BASE + 40'($urandom_range(0, 511));
            txn(0, t, a, sz, rpl(), 0, 0);
            t = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd2;
            sz = 3'($urandom_range(0, 6));
            txn(0, t, a, sz, rpl(), $urandom_range(0, 3),
                $urandom_range(0, 3));
            if ((r % 4) == 0) begin
                txn(0, 4'($urandom_range(4, 15)), a, 3'd3, rpl(), 0, 0);
                txn(0, 4'd2, a, 3'd3, rpl(), 0, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_burst_mem_responder.md
BP_BURST_MEM_RESPONDER -- requirements
Module: bp_burst_mem_responder

Interface
REQ-001 SHALL have parameters, one per line:
- dword_width_p, 64, data beat width.
- paddr_width_p, 40, address width.
- hdr_width_p, 128, header width.
- mem_els_p, 512, dword entries of backing store.
- mem_offset_p, 40'h80_0000_0000 >> 8 (= 32'h8000_0000), base address.
- latency_p, 8, fixed service latency in cycles.
REQ-002 SHALL use this header layout:
- [3:0] msg_type: 0=rd, 1=wr, 2=uc_rd, 3=uc_wr.
- [43:4] addr.
- [46:44] size, encoding 2^size bytes, 0..6.
- [hdr_width_p-1:47] payload, echoed unmodified.
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
- blackparrot_clk, in, 1, clock; all state updates on rising edge.
- blackparrot_reset, in, 1, reset, asynchronous, active-low.
- mem_cmd_header_i, in, hdr_width_p, command header.
- mem_cmd_header_v_i, in, 1, header valid.
- mem_cmd_header_ready_and_o, out, 1, header ready.
- mem_cmd_data_i, in, dword_width_p, write data beat.
- mem_cmd_data_v_i, in, 1, data valid.
- mem_cmd_data_ready_and_o, out, 1, data ready.
- mem_resp_header_o, out, hdr_width_p, response header.
- mem_resp_header_v_o, out, 1, response header valid.
- mem_resp_header_ready_and_i, in, 1, response header ready; a yumi is legal.
- mem_resp_data_o, out, dword_width_p, read data beat.
- mem_resp_data_v_o, out, 1, data valid.
- mem_resp_data_ready_and_i, in, 1, data ready; a yumi is legal.

Function
REQ-004 All channels SHALL be valid/ready-and; a transfer occurs only in a cycle with v=1 and ready=1. Outputs SHALL NOT depend combinationally on any ready input.
REQ-005 The FSM SHALL have the states IDLE, CMD_DATA, WAIT, RESP_HDR and RESP_DATA, and SHALL process one transaction at a time.
REQ-006 mem_cmd_header_ready_and_o SHALL be 1 only in IDLE. On a header transfer the block SHALL register the header.
- wr/uc_wr: go to CMD_DATA.
- All other msg_types: go to WAIT.
REQ-007 mem_cmd_data_ready_and_o SHALL be 1 only in CMD_DATA. Data beats offered outside CMD_DATA SHALL NOT be consumed.
REQ-008 Beat count N SHALL be max(1, 2^size/8).
- CMD_DATA SHALL accept exactly N beats, writing each beat in its transfer cycle.
- After beat N the block SHALL go to WAIT.
REQ-009 Dword index for beat i SHALL be (((addr-mem_offset_p)>>3) aligned down to N) + ((((addr-mem_offset_p)>>3)+i) mod N), all taken mod mem_els_p. This gives critical-word-first order with wrap inside the block; out-of-range addresses wrap and are not flagged.
REQ-010 When size<3, writes SHALL update only bytes addr[2:0] .. addr[2:0]+2^size-1, taking data from the low bytes of the beat. Bytes beyond bit 63 of the dword SHALL be dropped.
REQ-011 WAIT SHALL hold for exactly latency_p cycles, counted by a down-counter, then go to RESP_HDR. latency_p=0 SHALL go directly to RESP_HDR.
- Read: mem_resp_header_v_o rises latency_p+1 cycles after the command header transfer.
- Write: mem_resp_header_v_o rises latency_p+1 cycles after the final data beat.
REQ-012 In RESP_HDR, mem_resp_header_o SHALL equal the registered command header bit-for-bit and mem_resp_header_v_o SHALL be 1. On transfer:
- rd/uc_rd: go to RESP_DATA.
- Otherwise: go to IDLE.
REQ-013 RESP_DATA SHALL present N beats in REQ-009 order, one per transfer, with mem_resp_data_v_o=1. After beat N the block SHALL return to IDLE.
REQ-014 When size<3, a read beat SHALL carry the requested bytes right-justified, with upper bytes zero.
REQ-015 msg_type values 4..15 SHALL produce a header-only response and leave memory unchanged.
REQ-016 After a response completes, the next command header SHALL be accepted no earlier than the cycle after the return to IDLE, giving a minimum of one idle cycle between transactions.
REQ-017 The header and data value outputs SHALL be 0 whenever their v is 0.

Reset
REQ-018 While blackparrot_reset=0 the block SHALL immediately force the following, regardless of clock:
- FSM to IDLE; counters to 0.
- All v_o and ready_and_o outputs to 0.
- mem_resp_header_o and mem_resp_data_o to 0.
REQ-019 Reset mid-transaction SHALL abandon the transaction with no response; memory writes already completed SHALL persist.
REQ-020 The backing store SHALL NOT be reset; its content is undefined until written.
REQ-021 mem_cmd_header_ready_and_o SHALL rise in the first clock cycle after reset deasserts.

Verification
REQ-022 Directed scenarios:
- wr 64B at 0x8000_0040 with beats 0x11..0x88, then rd 64B at 0x8000_0050 -> response header echoes the command; data order 0x33,0x44,...,0x88,0x11,0x22; header v rises exactly 9 cycles after the read header transfer.
- uc_wr size=0 at 0x8000_0003, data 0xAB, onto a dword holding 0x0 -> uc_rd size=3 at 0x8000_0000 returns 0x0000_0000_AB00_0000.
- Random stalls: deassert ready on the resp header for 5 cycles and the resp data for 3 cycles -> v and data stay stable; no beat lost or duplicated.
- msg_type=7 with payload 0x5A -> header-only response with payload 0x5A; the next read of the same dword is unchanged.
- Reset asserted after 3 of 8 write beats -> all outputs 0 immediately; after release, a read of beats 0..2 returns the written data and header ready = 1.
- latency_p=0 -> read resp header v rises in the cycle after the cmd header transfer.
